// File: rtl/data_mem_responder.sv
// +----------------------------------------------------------------------------+
// | data_mem_responder                                                         |
// |   Fixed-latency data-memory responder for the MEM-stage load/store port.   |
// |   Optional misaligned-access checking: define DMEM_ALIGN_CHECK_EN.         |
// |   Revision: 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_mem_responder #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_valid,
   input  logic              i_req_read,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_req_ready,
   output logic              o_resp_valid,
   output logic [DATA_W-1:0] o_resp_rdata,
   output logic              o_stall,
   output logic              o_err
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_wdata;
   logic              r_rd;
   logic              r_wr;
   logic              r_mis;
   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

   logic              w_accept;
   logic              w_in_mis;
   logic [IDX_W-1:0]  w_in_idx;
   logic              w_enter;
   logic [IDX_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_wdata;
   logic              w_rd;
   logic              w_wr;
   logic              w_mis;
   logic              w_we;
   logic              w_unused_addr;

   assign w_in_idx      = i_req_addr[IDX_W+1:2];
   assign w_unused_addr = ^{i_req_addr[ADDR_W-1:IDX_W+2], i_req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
   assign w_in_mis = (i_req_addr[1:0] != 2'b00);
`else
   assign w_in_mis = 1'b0;
`endif

   // Gated by rst_n so a request held during reset is neither stalled on nor accepted.
   assign w_accept = rst_n && (r_state == ST_IDLE) && i_req_valid && (i_req_read || i_req_write);

   // With zero latency the request goes straight from the ports to the response edge.
   always_comb begin
      w_enter = 1'b0;
      w_idx   = r_idx;
      w_wdata = r_wdata;
      w_rd    = r_rd;
      w_wr    = r_wr;
      w_mis   = r_mis;
      if (LATENCY == 0) begin
         w_enter = w_accept;
         w_idx   = w_in_idx;
         w_wdata = i_req_wdata;
         w_rd    = i_req_read;
         w_wr    = i_req_write;
         w_mis   = w_in_mis;
      end else begin
         w_enter = rst_n && (r_state == ST_BUSY) && (r_cnt == 4'd0);
      end
   end

   assign w_we        = w_enter && w_wr && !w_mis;
   assign o_req_ready = (r_state == ST_IDLE);
   assign o_stall     = w_accept || (r_state == ST_BUSY);

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_idx] <= w_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 4'd0;
         r_idx        <= '0;
         r_wdata      <= '0;
         r_rd         <= 1'b0;
         r_wr         <= 1'b0;
         r_mis        <= 1'b0;
         o_resp_valid <= 1'b0;
         o_resp_rdata <= '0;
         o_err        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_idx   <= w_in_idx;
                  r_wdata <= i_req_wdata;
                  r_rd    <= i_req_read;
                  r_wr    <= i_req_write;
                  r_mis   <= w_in_mis;
                  if (LATENCY == 0) begin
                     r_state <= ST_RESP;
                  end else begin
                     r_state <= ST_BUSY;
                     r_cnt   <= CNT_INIT;
                  end
               end
            end
            ST_BUSY: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase

         o_resp_valid <= w_enter;
         o_err        <= w_enter && w_mis;
         // Array read sees the pre-write word, giving read-before-write on combined ops.
         if (w_enter && w_rd) begin
            o_resp_rdata <= w_mis ? '0 : r_mem[w_idx];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// +----------------------------------------------------------------------------+
// | tb_data_mem_responder                                                      |
// |   Directed bench: LATENCY=2 and LATENCY=0 instances of data_mem_responder. |
// |   Revision: 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  r_valid = 2'b00;
   logic        r_read = 1'b0;
   logic        r_write = 1'b0;
   logic [31:0] r_addr = '0;
   logic [31:0] r_wdata = '0;

   logic        w_ready0, w_rv0, w_stall0, w_err0;
   logic        w_ready1, w_rv1, w_stall1, w_err1;
   logic [31:0] w_rdata0, w_rdata1;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.LATENCY(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(r_valid[0]), .i_req_read(r_read), .i_req_write(r_write),
      .i_req_addr(r_addr), .i_req_wdata(r_wdata),
      .o_req_ready(w_ready0), .o_resp_valid(w_rv0), .o_resp_rdata(w_rdata0),
      .o_stall(w_stall0), .o_err(w_err0)
   );

   data_mem_responder #(.LATENCY(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(r_valid[1]), .i_req_read(r_read), .i_req_write(r_write),
      .i_req_addr(r_addr), .i_req_wdata(r_wdata),
      .o_req_ready(w_ready1), .o_resp_valid(w_rv1), .o_resp_rdata(w_rdata1),
      .o_stall(w_stall1), .o_err(w_err1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // One access on the chosen instance; verifies stall count, response timing, data and err.
   task automatic access(input int dut, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic chk_rd, input logic [31:0] exp_rd,
                         input logic exp_err, input string tag);
      int lat;
      int stalls;
      int n;
      bit got;
      lat    = (dut == 0) ? 2 : 0;
      stalls = 0;
      n      = -1;
      got    = 1'b0;
      @(negedge clk);
      r_read  = rd;
      r_write = wr;
      r_addr  = a;
      r_wdata = d;
      r_valid[dut] = 1'b1;
      #1;
      check({tag, " ready@req"}, {31'd0, (dut == 0) ? w_ready0 : w_ready1}, 32'd1);
      for (int c = 0; c < 20; c++) begin
         if ((dut == 0) ? w_stall0 : w_stall1) stalls++;
         if ((dut == 0) ? w_rv0 : w_rv1) begin
            got = 1'b1;
            n   = c;
            check({tag, " err"}, {31'd0, (dut == 0) ? w_err0 : w_err1}, {31'd0, exp_err});
            check({tag, " ready@resp"}, {31'd0, (dut == 0) ? w_ready0 : w_ready1}, 32'd0);
            if (chk_rd) check({tag, " rdata"}, (dut == 0) ? w_rdata0 : w_rdata1, exp_rd);
            break;
         end
         @(negedge clk);
         r_valid = 2'b00;
         #1;
      end
      check({tag, " resp seen"}, {31'd0, got}, 32'd1);
      check({tag, " resp cycle"}, n, lat + 1);
      check({tag, " stall cycles"}, stalls, lat + 1);
      @(negedge clk);
      r_valid = 2'b00;
      #1;
      check({tag, " single pulse"}, {31'd0, (dut == 0) ? w_rv0 : w_rv1}, 32'd0);
   endtask

   initial begin
      int pulses;
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst ready",  {31'd0, w_ready0}, 32'd1);
      check("rst rvalid", {31'd0, w_rv0},    32'd0);
      check("rst rdata",  w_rdata0,          32'd0);
      check("rst stall",  {31'd0, w_stall0}, 32'd0);
      check("rst err",    {31'd0, w_err0},   32'd0);
      check("rst rdata1", w_rdata1,          32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic write then read, LATENCY=2
      access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "t1 wr");
      access(0, 1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, "t1 rd");

      // LATENCY=0 instance
      access(1, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0, 1'b0, "t2 wr");
      access(1, 1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 32'h12345678, 1'b0, "t2 rd");

      // Address wrap over 256 words
      access(0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, "t3 wr");
      access(0, 1'b1, 1'b0, 32'h000, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0, "t3 rd");

      // Combined read+write is a write with read-before-write data
      access(0, 1'b0, 1'b1, 32'h8, 32'h1, 1'b0, 32'h0, 1'b0, "t4 wr");
      access(0, 1'b1, 1'b1, 32'h8, 32'h2, 1'b1, 32'h1, 1'b0, "t4 rw");
      access(0, 1'b0, 1'b1, 32'hC, 32'h3, 1'b1, 32'h1, 1'b0, "t4 hold");
      access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'h2, 1'b0, "t4 rd");

      // Reset during BUSY drops the pending write
      access(0, 1'b0, 1'b1, 32'h30, 32'h11, 1'b0, 32'h0, 1'b0, "t5 pre");
      @(negedge clk);
      r_read = 1'b0; r_write = 1'b1; r_addr = 32'h30; r_wdata = 32'h55;
      r_valid = 2'b01;
      @(negedge clk);
      r_valid = 2'b00;
      rst_n   = 1'b0;
      #1;
      check("t5 ready",  {31'd0, w_ready0}, 32'd1);
      check("t5 rvalid", {31'd0, w_rv0},    32'd0);
      check("t5 rdata",  w_rdata0,          32'd0);
      check("t5 stall",  {31'd0, w_stall0}, 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (w_rv0) pulses++;
      end
      check("t5 no resp", pulses, 0);
      access(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 32'h11, 1'b0, "t5 rd");

      // Misaligned access
      access(0, 1'b0, 1'b1, 32'h40, 32'h99, 1'b0, 32'h0, 1'b0, "t6 pre");
`ifdef DMEM_ALIGN_CHECK_EN
      access(0, 1'b0, 1'b1, 32'h42, 32'h77, 1'b0, 32'h0, 1'b1, "t6 wr");
      access(0, 1'b1, 1'b0, 32'h40, 32'h0,  1'b1, 32'h99, 1'b0, "t6 rd");
      access(0, 1'b1, 1'b0, 32'h41, 32'h0,  1'b1, 32'h0,  1'b1, "t6 mrd");
`else
      access(0, 1'b0, 1'b1, 32'h42, 32'h77, 1'b0, 32'h0, 1'b0, "t6 wr");
      access(0, 1'b1, 1'b0, 32'h40, 32'h0,  1'b1, 32'h77, 1'b0, "t6 rd");
      access(0, 1'b1, 1'b0, 32'h43, 32'h0,  1'b1, 32'h77, 1'b0, "t6 mrd");
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
